// File: rtl/uart_transmitter.sv
`timescale 1ns/1ps
// UART transmit stage: start bit, 8 data bits MSB first, optional even parity, stop bit; 16 ticks per bit.
// Optional feature macro UART_TX_PARITY_EN: defined -> 11-bit frame with parity, undefined -> 10-bit frame.
module uart_transmitter #(
    parameter int CLK_FREQ = 50_000_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       Tx_EN,
    input  logic       Tx_WR,
    input  logic [7:0] Tx_DATA,
    input  logic [2:0] Tx_baud_select,
    output logic       TxD,
    output logic       Tx_BUSY,
    output logic       Tx_DONE
);

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

    // Rounded 16x-tick divisor; must stay below 2**14 for the slowest rate.
    function automatic logic [13:0] div_of(input int baud);
        return 14'((CLK_FREQ + 8 * baud) / (16 * baud));
    endfunction

    function automatic logic [13:0] div_last(input logic [2:0] sel);
        logic [13:0] d;
        case (sel)
            3'd0:    d = div_of(300);
            3'd1:    d = div_of(1200);
            3'd2:    d = div_of(4800);
            3'd3:    d = div_of(9600);
            3'd4:    d = div_of(19200);
            3'd5:    d = div_of(38400);
            3'd6:    d = div_of(57600);
            default: d = div_of(115200);
        endcase
        return d - 14'd1;
    endfunction

    state_t      state, state_next;
    logic [13:0] div_cnt, div_next;
    logic [3:0]  tick_cnt, tick_next;
    logic [2:0]  bit_idx, idx_next;
    logic [7:0]  shift_reg, shift_next;
    logic [2:0]  sel_q, sel_next;
    logic        txd_q, txd_next;
    logic        done_q, done_next;
    logic        bit_end;
`ifdef UART_TX_PARITY_EN
    logic        parity_q, parity_next;
`endif

    // NOTE: every signal gets a default before any branch so no latch is inferred.
    always_comb begin
        state_next = state;
        div_next   = div_cnt;
        tick_next  = tick_cnt;
        idx_next   = bit_idx;
        shift_next = shift_reg;
        sel_next   = sel_q;
        done_next  = 1'b0;
        bit_end    = 1'b0;
`ifdef UART_TX_PARITY_EN
        parity_next = parity_q;
`endif
        if (!Tx_EN) begin
            state_next = IDLE;
            div_next   = '0;
            tick_next  = '0;
            idx_next   = '0;
        end else if (state == IDLE) begin
            if (Tx_WR) begin
                state_next = START;
                shift_next = Tx_DATA;
                sel_next   = Tx_baud_select;
                div_next   = '0;
                tick_next  = '0;
                idx_next   = '0;
`ifdef UART_TX_PARITY_EN
                parity_next = ^Tx_DATA;
`endif
            end
        end else begin
            if (div_cnt == div_last(sel_q)) begin
                div_next  = '0;
                tick_next = tick_cnt + 4'd1;
                bit_end   = (tick_cnt == 4'd15);
            end else begin
                div_next = div_cnt + 14'd1;
            end
            if (bit_end) begin
                case (state)
                    START: state_next = DATA;
                    DATA: begin
                        shift_next = {shift_reg[6:0], 1'b0};
                        idx_next   = bit_idx + 3'd1;
                        if (bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                            state_next = PARITY;
`else
                            state_next = STOP;
`endif
                        end
                    end
`ifdef UART_TX_PARITY_EN
                    PARITY: state_next = STOP;
`endif
                    STOP: begin
                        state_next = IDLE;
                        done_next  = 1'b1;
                    end
                    default: state_next = IDLE;
                endcase
            end
        end

        // Line level is registered from the next state so TxD is glitch-free.
        case (state_next)
            START:   txd_next = 1'b0;
            DATA:    txd_next = shift_next[7];
`ifdef UART_TX_PARITY_EN
            PARITY:  txd_next = parity_next;
`endif
            default: txd_next = 1'b1;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            div_cnt   <= '0;
            tick_cnt  <= '0;
            bit_idx   <= '0;
            shift_reg <= '0;
            sel_q     <= '0;
            txd_q     <= 1'b1;
            done_q    <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_q  <= 1'b0;
`endif
        end else begin
            state     <= state_next;
            div_cnt   <= div_next;
            tick_cnt  <= tick_next;
            bit_idx   <= idx_next;
            shift_reg <= shift_next;
            sel_q     <= sel_next;
            txd_q     <= txd_next;
            done_q    <= done_next;
`ifdef UART_TX_PARITY_EN
            parity_q  <= parity_next;
`endif
        end
    end

    assign TxD     = txd_q;
    assign Tx_BUSY = (state != IDLE);
    assign Tx_DONE = done_q;

endmodule

// File: tb/tb_uart_transmitter.sv
`timescale 1ns/1ps
// Scoreboard bench for uart_transmitter: stimulus queues expected frames, a negedge monitor decodes TxD.
module tb_uart_transmitter;

`ifdef UART_TX_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif
    localparam int P7 = 16 * 27;
    localparam int P3 = 16 * 326;

    typedef struct {
        logic [7:0] data;
        int         period;
        bit         abort;
        bit         b2b;
    } item_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       Tx_EN = 1'b0;
    logic       Tx_WR = 1'b0;
    logic [7:0] Tx_DATA = 8'h00;
    logic [2:0] Tx_baud_select = 3'd7;
    logic       TxD, Tx_BUSY, Tx_DONE;

    int checks = 0;
    int errors = 0;

    item_t exp_q[$];
    item_t cur;
    logic [10:0] bits;
    bit  in_frame = 1'b0;
    bit  stray = 1'b0;
    int  cyc = 0, c = 0, bad = 0, fidx = 0, done_cyc = -10, idle_bad = 0;

    uart_transmitter #(.CLK_FREQ(50_000_000)) dut (
        .clk(clk), .reset(reset), .Tx_EN(Tx_EN), .Tx_WR(Tx_WR), .Tx_DATA(Tx_DATA),
        .Tx_baud_select(Tx_baud_select), .TxD(TxD), .Tx_BUSY(Tx_BUSY), .Tx_DONE(Tx_DONE)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [10:0] frame_bits(input logic [7:0] d);
        logic [10:0] b;
        b    = '1;
        b[0] = 1'b0;
        for (int i = 0; i < 8; i++) b[1 + i] = d[7 - i];
`ifdef UART_TX_PARITY_EN
        b[9] = ^d;
`endif
        return b;
    endfunction

    // Monitor: decodes each frame clock by clock against the queued expectation.
    always @(negedge clk) begin
        cyc++;
        if (!in_frame && !Tx_BUSY) begin
            stray = 1'b0;
            if (TxD !== 1'b1 || Tx_DONE !== 1'b0) idle_bad++;
        end
        if (!in_frame && Tx_BUSY && !stray) begin
            check("frame_queued", exp_q.size() > 0, 1'b1);
            if (exp_q.size() > 0) begin
                cur = exp_q.pop_front();
                fidx++;
                c = 0;
                bad = 0;
                in_frame = 1'b1;
                bits = frame_bits(cur.data);
                if (cur.b2b) check($sformatf("f%0d_gap", fidx), cyc - done_cyc, 1);
            end else begin
                stray = 1'b1;
            end
        end
        if (in_frame) begin
            if (c < NB * cur.period && !Tx_BUSY) begin
                check($sformatf("f%0d_abort", fidx), {cur.abort, TxD, Tx_DONE}, 3'b110);
                in_frame = 1'b0;
            end else if (c < NB * cur.period) begin
                if (TxD !== bits[c / cur.period] || Tx_DONE !== 1'b0) bad++;
                if (c % cur.period == cur.period - 1) begin
                    check($sformatf("f%0d_bit%0d_bad_samples", fidx, c / cur.period), bad, 0);
                    bad = 0;
                end
                c++;
            end else begin
                check($sformatf("f%0d_end", fidx), {cur.abort, Tx_DONE, Tx_BUSY, TxD}, 4'b0101);
                done_cyc = cyc;
                in_frame = 1'b0;
            end
        end
    end

    task automatic send(input logic [7:0] d, input logic [2:0] sel, input int period,
                        input bit ab, input bit b2b);
        item_t it;
        if (!b2b) @(negedge clk);
        Tx_WR = 1'b1;
        Tx_DATA = d;
        Tx_baud_select = sel;
        it.data = d;
        it.period = period;
        it.abort = ab;
        it.b2b = b2b;
        exp_q.push_back(it);
        @(negedge clk);
        Tx_WR = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input int budget);
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            #1;
            if (!in_frame && exp_q.size() == 0) break;
        end
        check({"idle_", tag}, {in_frame, exp_q.size() != 0}, 2'b00);
    endtask

    initial begin
        bit got;
        #1 reset = 1'b0;
        #2 check("reset_values", {TxD, Tx_BUSY, Tx_DONE}, 3'b100);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        Tx_EN = 1'b1;

        // 0xA5 at 115200, with an ignored 0xFF write mid-frame.
        send(8'hA5, 3'd7, P7, 1'b0, 1'b0);
        repeat (2000) @(negedge clk);
        Tx_WR = 1'b1;
        Tx_DATA = 8'hFF;
        @(negedge clk);
        Tx_WR = 1'b0;
        wait_idle("a5", 6000);

        // Write in the same cycle Tx_EN is low: must be ignored.
        @(negedge clk);
        Tx_EN = 1'b0;
        Tx_WR = 1'b1;
        Tx_DATA = 8'h81;
        @(negedge clk);
        Tx_WR = 1'b0;
        Tx_EN = 1'b1;
        repeat (4) @(negedge clk);
        check("en_low_write_ignored", {Tx_BUSY, TxD}, 2'b01);

        // Abort by Tx_EN during data bit 3.
        send(8'h96, 3'd7, P7, 1'b1, 1'b0);
        repeat (4 * P7 + 200) @(negedge clk);
        Tx_EN = 1'b0;
        @(posedge clk);
        #1 check("en_abort_next_edge", {TxD, Tx_BUSY, Tx_DONE}, 3'b100);
        @(negedge clk);
        Tx_EN = 1'b1;

        // Clean frame, then 0x3C written in its Tx_DONE cycle.
        send(8'hC3, 3'd7, P7, 1'b0, 1'b0);
        got = 1'b0;
        for (int i = 0; i < 6000; i++) begin
            @(negedge clk);
            #1;
            if (Tx_DONE) begin
                got = 1'b1;
                break;
            end
        end
        check("b2b_done_seen", got, 1'b1);
        send(8'h3C, 3'd7, P7, 1'b0, 1'b1);
        wait_idle("b2b", 6000);

        // 0x00 at 9600 with select moved to 115200 during the start bit.
        send(8'h00, 3'd3, P3, 1'b0, 1'b0);
        repeat (2000) @(negedge clk);
        Tx_baud_select = 3'd7;
        wait_idle("sel3", 60000);

        // Asynchronous reset mid-frame.
        send(8'h5A, 3'd7, P7, 1'b1, 1'b0);
        repeat (1000) @(negedge clk);
        #2 reset = 1'b0;
        #1 check("reset_async_mid_frame", {TxD, Tx_BUSY, Tx_DONE}, 3'b100);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        wait_idle("reset", 100);

        repeat (10) @(negedge clk);
        check("idle_line_quiet", idle_bad, 0);
        check("queue_drained", exp_q.size(), 0);
        check("frames_seen", fidx, 6);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/uart_transmitter.md
# uart_transmitter

Serial transmit stage of the UART link: accepts one byte per write handshake and drives the framed serial line (TxD) that feeds the uart_receiver's RxD input. Frame format matches the receiver exactly:
- start bit, 8 data bits MSB first, even parity bit, stop bit;
- each bit lasts 16 ticks of an internal 16x baud-tick generator.

## Interface
- CLK_FREQ, 50_000_000: clock frequency in Hz, used to derive baud divisors.
- clk  input  1  system clock, all logic on rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- Tx_EN  input  1  transmitter enable; 0 aborts and holds block idle.
- Tx_WR  input  1  write strobe; one-cycle pulse requests transmission of Tx_DATA.
- Tx_DATA  input  8  byte to send, sampled on the accepted Tx_WR cycle.
- Tx_baud_select  input  3  rate: 0=300, 1=1200, 2=4800, 3=9600, 4=19200, 5=38400, 6=57600, 7=115200 baud.
- TxD  output  1  serial line, idle high.
- Tx_BUSY  output  1  high while a frame is in progress.
- Tx_DONE  output  1  one-cycle pulse when stop bit completes.

## Operation
- Reset values: TxD=1, Tx_BUSY=0, Tx_DONE=0, state IDLE, all counters 0.
- Tick divisor: DIV = round(CLK_FREQ/(16*baud)). At 50 MHz, selects 0..7 give DIV = 10417, 2604, 651, 326, 163, 81, 54, 27.
- Divisor counter: 14-bit, counts 0..DIV-1, emitting a tick on DIV-1.
- Tick counter: 4-bit, counts 16 ticks per bit.
- Accept: Tx_WR=1 && Tx_EN=1 && Tx_BUSY=0 latches Tx_DATA into the shift register and Tx_baud_select into a frame-local register.
  - Baud select changes mid-frame have no effect.
  - Divisor and tick counters restart at 0 on accept.
- Ignored writes: Tx_WR while Tx_BUSY=1 or Tx_EN=0 is ignored; no state change.
- States:
  - IDLE: TxD=1.
  - START: TxD=0.
  - DATA: TxD=shift[7], shift left each bit, 3-bit index 0..7.
  - PARITY: TxD = XOR of the 8 latched data bits.
  - STOP: TxD=1.
- Transitions: IDLE→START on accept. START→DATA, DATA→DATA (index<7), DATA→PARITY (index=7), PARITY→STOP, STOP→IDLE, each after 16 ticks.
- Parity: computed from the latched byte, not from live Tx_DATA.
- Tx_EN=0 at any time: synchronously forces IDLE on the next edge (TxD=1, Tx_BUSY=0, counters cleared, no Tx_DONE).
- reset asserted mid-frame: immediate return to reset values.

## Timing
- Accept edge N: TxD=0 and Tx_BUSY=1 are visible after edge N, with no extra latency.
- Each bit lasts exactly 16*DIV clocks.
- Frame length is 11*16*DIV clocks (10*16*DIV without parity).
- Tx_DONE=1 and Tx_BUSY=0 appear in the same cycle, immediately after the last stop-bit clock. State is then IDLE.
- Back-to-back frames: a write in the cycle Tx_DONE is high sees Tx_BUSY=0 and is accepted. The next start bit follows with zero idle gap beyond the full stop bit.
- Tx_WR and Tx_EN falling in the same cycle: Tx_EN wins, write is ignored.

## Configuration
- UART_TX_PARITY_EN
  - Defined: PARITY state present, 11-bit frame, compatible with uart_receiver.
  - Undefined: PARITY state removed (DATA index=7 → STOP), 10-bit frame. All other timing is unchanged.

## Test plan
- Reset: assert reset low mid-frame at select 7 → TxD=1, Tx_BUSY=0, Tx_DONE=0 immediately, with no clk edge required.
- Send 0xA5 at select 7 (DIV=27, 432 clocks/bit), parity enabled → TxD sequence 0,1,0,1,0,0,1,0,1,0,1, each 432 clocks. Tx_BUSY high for 4752 clocks, then one Tx_DONE pulse.
- Send 0x00 at select 3 (DIV=326) → start bit, 8 zeros, parity 0, stop 1, each 5216 clocks.
  - Change Tx_baud_select to 7 mid-frame → bit periods unchanged.
- Tx_WR with 0xFF during an active 0xA5 frame → ignored; 0xA5 frame completes intact, no second frame.
- Deassert Tx_EN during data bit 3 → TxD=1 and Tx_BUSY=0 after the next edge, no Tx_DONE. A subsequent write with Tx_EN=1 sends a clean full frame.
- Back-to-back: write 0x3C in the Tx_DONE cycle of a prior frame → start bit begins right after the previous stop bit.
  - Loopback into uart_receiver gives Rx_DATA=0x3C, Rx_VALID=1, Rx_PERROR=0, Rx_FERROR=0.
  - Build without UART_TX_PARITY_EN → frame is 10*432 clocks at select 7.
